// File: rtl/seq_restoring_div32_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_restoring_div32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_trial_sub32.sv
// Trial subtraction for one restoring-division step: computes T[31:0] - D
// through a 32-bit Kogge-Stone prefix adder (T + ~D + 1) and reports whether
// the subtraction succeeds, including the case where T overflows 32 bits.
module div_trial_sub32 (
  input  logic [32:0] t,
  input  logic [31:0] d,
  output logic [31:0] diff,
  output logic        ok
);

  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] gl;
  logic [31:0] pl;
  logic [31:0] gn;
  logic [31:0] pn;
  logic        cout;

  assign a   = t[31:0];
  assign b   = ~d;
  assign cin = 1'b1;

  // Kogge-Stone prefix network; carry-in folded into bit 0's generate.
  always_comb begin
    gl    = a & b;
    pl    = a ^ b;
    gl[0] = gl[0] | (pl[0] & cin);
    gn    = gl;
    pn    = pl;
    for (int l = 0; l < 5; l++) begin
      gn = gl;
      pn = pl;
      for (int i = (1 << l); i < 32; i++) begin
        gn[i] = gl[i] | (pl[i] & gl[i - (1 << l)]);
        pn[i] = pl[i] & pl[i - (1 << l)];
      end
      gl = gn;
      pl = pn;
    end
    diff = (a ^ b) ^ {gl[30:0], cin};
    cout = gl[31];
  end

  // A set bit 32 means T >= 2^32 > D, so the step always succeeds.
  assign ok = t[32] | cout;

endmodule

// File: rtl/seq_restoring_div32.sv
// Unsigned 32/32 iterative restoring divider, one quotient bit per clock,
// with a start/done handshake and divide-by-zero detection.
module seq_restoring_div32
  import seq_restoring_div32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // The trial subtractor is hard-wired to 32 bits.
  if (WIDTH != 32) begin : g_bad_width
    $error("seq_restoring_div32: only WIDTH=32 is supported");
  end

  div_state_t  state;
  div_state_t  state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dsr_r;
  logic [32:0] trial;
  logic [31:0] diff;
  logic        ok;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic        accept;
  logic        last;

  assign accept = start && (state != CALC);
  assign last   = (state == CALC) && (cnt == 5'(DIV_ITERS - 1));

  // Step datapath: shift the next dividend bit into the partial remainder.
  assign trial   = {rem_r, quo_r[31]};
  assign rem_nxt = ok ? diff : trial[31:0];
  assign quo_nxt = {quo_r[30:0], ok};

  div_trial_sub32 u_trial (
    .t    (trial),
    .d    (dsr_r),
    .diff (diff),
    .ok   (ok)
  );

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; IDLE and DONE both accept a new request.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)              state_nxt = (divisor == '0) ? DONE : CALC;
        else if (state == DONE) state_nxt = IDLE;
      end
      CALC:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers, iteration counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dsr_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor != '0) begin
        dsr_r       <= divisor;
        rem_r       <= '0;
        quo_r       <= dividend;
        cnt         <= '0;
        div_by_zero <= 1'b0;
      end else begin
        quotient    <= DIV_BY_ZERO_Q;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      cnt   <= cnt + 5'd1;
      if (last) begin
        quotient  <= quo_nxt;
        remainder <= rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_div32.sv
// Directed and randomized bench for the sequential restoring divider.
module tb_seq_restoring_div32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  seq_restoring_div32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for done; n is edges after the start edge.
  task automatic run_op(input logic [31:0] dd, input logic [31:0] ds,
                        output int n, output int bc);
    dividend = dd;
    divisor  = ds;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n  = 0;
    bc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl got busy/done/dbz=%b required 000", {busy, done, div_by_zero});
    end
    vectors++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data got q=%h r=%h required 0/0", quotient, remainder);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int n, bc;
    run_op(32'd100, 32'd7, n, bc);
    vectors++;
    if (n !== 32) begin
      miscompares++;
      $display("FAIL basic_latency got %0d required 32", n);
    end
    vectors++;
    if (bc !== 32) begin
      miscompares++;
      $display("FAIL basic_busy_cycles got %0d required 32", bc);
    end
    vectors++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result got q=%0d r=%0d z=%b required 14/2/0", quotient, remainder, div_by_zero);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_done_pulse got done=%b busy=%b required 0/0", done, busy);
    end
    vectors++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      miscompares++;
      $display("FAIL basic_hold got q=%0d r=%0d required 14/2", quotient, remainder);
    end
  endtask

  task automatic test_t32();
    int n, bc;
    run_op(32'hFFFF_FFFF, 32'h8000_0000, n, bc);
    vectors++;
    if (quotient !== 32'd1 || remainder !== 32'h7FFF_FFFF || n !== 32) begin
      miscompares++;
      $display("FAIL t32_a got q=%h r=%h lat=%0d required 1/7fffffff/32", quotient, remainder, n);
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, n, bc);
    vectors++;
    if (quotient !== 32'd0 || remainder !== 32'h8000_0000 || n !== 32) begin
      miscompares++;
      $display("FAIL t32_b got q=%h r=%h lat=%0d required 0/80000000/32", quotient, remainder, n);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int n, bc;
    run_op(32'd5, 32'd0, n, bc);
    vectors++;
    if (n !== 0 || bc !== 0) begin
      miscompares++;
      $display("FAIL dbz_latency got n=%0d busy=%0d required 0/0", n, bc);
    end
    vectors++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL dbz_result got q=%h r=%0d z=%b required ffffffff/5/1", quotient, remainder, div_by_zero);
    end
    run_op(32'd3, 32'd10, n, bc);
    vectors++;
    if (quotient !== 32'd0 || remainder !== 32'd3 || div_by_zero !== 1'b0 || n !== 32) begin
      miscompares++;
      $display("FAIL dbz_after got q=%0d r=%0d z=%b lat=%0d required 0/3/0/32",
               quotient, remainder, div_by_zero, n);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == 10) begin
        dividend = 32'd9;
        divisor  = 32'd9;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    vectors++;
    if (quotient !== 32'd333 || remainder !== 32'd1 || n !== 32) begin
      miscompares++;
      $display("FAIL ignore_start got q=%0d r=%0d lat=%0d required 333/1/32", quotient, remainder, n);
    end
    // Request issued in the done cycle must be accepted with no gap.
    dividend = 32'd9;
    divisor  = 32'd9;
    start    = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept got busy=%b done=%b required 1/0", busy, done);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (quotient !== 32'd1 || remainder !== 32'd0 || n !== 32) begin
      miscompares++;
      $display("FAIL b2b_result got q=%0d r=%0d lat=%0d required 1/0/32", quotient, remainder, n);
    end
    tick();
  endtask

  task automatic test_abort();
    int n, bc, seen;
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      miscompares++;
      $display("FAIL abort_async got busy/done/z=%b q=%h r=%h required 000/0/0",
               {busy, done, div_by_zero}, quotient, remainder);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) rst_n = 1'b1;
      tick();
      if (done === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done got %0d done cycles required 0", seen);
    end
    run_op(32'hFFFF_FFFF, 32'd1, n, bc);
    vectors++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd0 || n !== 32) begin
      miscompares++;
      $display("FAIL abort_reissue got q=%h r=%h lat=%0d required ffffffff/0/32", quotient, remainder, n);
    end
    tick();
  endtask

  task automatic test_random();
    int n, bc;
    logic [31:0] dd, ds, eq, er;
    for (int k = 0; k < 200; k++) begin
      dd = $urandom;
      ds = (k % 2 == 0) ? $urandom : 32'($urandom_range(1, 255));
      if (ds == 32'd0) ds = 32'd1;
      eq = dd / ds;
      er = dd % ds;
      run_op(dd, ds, n, bc);
      vectors++;
      if (quotient !== eq || remainder !== er || n !== 32 || div_by_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_%0d %h/%h got q=%h r=%h lat=%0d required q=%h r=%h lat=32",
                 k, dd, ds, quotient, remainder, n, eq, er);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_t32();
    test_div_zero();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
